// File: rtl/sysref_phase_pkg.sv
// Shared status-word layout for the SYSREF phase tracker.
package sysref_phase_pkg;

    localparam int PHASE_W      = 16;
    localparam int PH_VALID     = 8;
    localparam int PH_LOCKED    = 9;
    localparam int PH_SLIP      = 10;
    localparam int PH_MISS      = 11;
    localparam int PH_MATCH_LSB = 12;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [3:0] match;
        logic       miss;
        logic       slip;
        logic       locked;
        logic       valid;
        logic [7:0] phase;
    } status_t;

endpackage

// File: rtl/phase_mod_add.sv
// Registered (phase + offset) mod PERIOD; phase < PERIOD and PERIOD >= 16,
// so two conditional subtractions always bring the sum back into range.
module phase_mod_add #(
    parameter int PERIOD = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] phase,
    input  logic [4:0] offset,
    output logic [7:0] target
);

    localparam logic [8:0] P9 = 9'(PERIOD);

    logic [8:0] sum0;
    logic [8:0] sum1;

    always_comb begin
        sum0 = {1'b0, phase} + {4'b0, offset};
        sum1 = (sum0 >= P9) ? sum0 - P9 : sum0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
        end else begin
            target <= (sum1 >= P9) ? 8'(sum1 - P9) : sum1[7:0];
        end
    end

endmodule

// File: rtl/sysref_phase_tracker.sv
// Measures SYSREF edge phase against a modulo-PERIOD aclk counter, qualifies lock,
// flags slip/missing and issues the sync strobe. Optional macro: SYSREF_PHASE_REALIGN_EN.
module sysref_phase_tracker
    import sysref_phase_pkg::*;
#(
    parameter int PERIOD     = 24,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 48
) (
    input  logic               aclk_i,
    input  logic               aresetn_i,
    input  logic               sysref_i,
    input  logic [4:0]         sync_offset_i,
    input  logic               clear_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               locked_o,
    output logic               sync_o
);

    localparam int                MISS_W   = $clog2(MISS_LIMIT + 1);
    localparam logic [7:0]        CNT_MAX  = 8'(PERIOD - 1);
    localparam logic [3:0]        LOCK_MAX = 4'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

    logic [7:0]        cnt;
    logic [7:0]        cnt_nxt;
    logic [7:0]        edge_phase;
    logic [7:0]        target;
    logic              sysref_q;
    logic              rise;
    logic              realign;
    logic              sync_nxt;
    logic              set_slip;
    logic              set_miss;
    logic [3:0]        match_inc;
    logic [MISS_W-1:0] miss_cnt;
    logic [MISS_W-1:0] miss_nxt;
    status_t           st;
    status_t           st_nxt;

    assign rise = sysref_i & ~sysref_q;

    always_comb begin
`ifdef SYSREF_PHASE_REALIGN_EN
        realign = rise && (st.match == 4'd0);
`else
        realign = 1'b0;
`endif
        edge_phase = realign ? 8'd0 : cnt;
        cnt_nxt    = (cnt == CNT_MAX) ? 8'd0 : cnt + 8'd1;
        if (realign) begin
            cnt_nxt = 8'd1;
        end

        match_inc = (st.match == LOCK_MAX) ? st.match : st.match + 4'd1;
        st_nxt    = st;
        miss_nxt  = miss_cnt;
        set_slip  = 1'b0;
        set_miss  = 1'b0;

        // A rise always takes priority over the miss timer reaching its limit.
        if (rise) begin
            st_nxt.phase = edge_phase;
            st_nxt.valid = 1'b1;
            miss_nxt     = '0;
            if (st.valid && (edge_phase == st.phase)) begin
                st_nxt.match  = match_inc;
                st_nxt.locked = (match_inc == LOCK_MAX);
            end else begin
                st_nxt.match  = '0;
                st_nxt.locked = 1'b0;
                set_slip      = st.locked;
            end
        end else if (miss_cnt != MISS_MAX) begin
            miss_nxt = miss_cnt + MISS_W'(1);
            if (miss_nxt == MISS_MAX) begin
                set_miss      = 1'b1;
                st_nxt.locked = 1'b0;
                st_nxt.match  = '0;
            end
        end

        st_nxt.slip = (st.slip & ~clear_i) | set_slip;
        st_nxt.miss = (st.miss & ~clear_i) | set_miss;

        // Gate with next-state lock so a capture change never fires on the stale target.
        sync_nxt = st_nxt.locked & (cnt == target);
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            cnt      <= '0;
            sysref_q <= 1'b0;
            st       <= '0;
            miss_cnt <= '0;
            sync_o   <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            sysref_q <= sysref_i;
            st       <= st_nxt;
            miss_cnt <= miss_nxt;
            sync_o   <= sync_nxt;
        end
    end

    phase_mod_add #(
        .PERIOD (PERIOD)
    ) u_target (
        .clk    (aclk_i),
        .rst_n  (aresetn_i),
        .phase  (st.phase),
        .offset (sync_offset_i),
        .target (target)
    );

    assign phase_o  = st;
    assign locked_o = st.locked;

endmodule

// File: tb/tb_sysref_phase_tracker.sv
// Directed, table-driven bench for sysref_phase_tracker (PERIOD=24, LOCK_COUNT=4, MISS_LIMIT=48).
`timescale 1ns/1ps
module tb_sysref_phase_tracker;

    localparam int P = 24;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic        sysref  = 1'b0;
    logic        clear   = 1'b0;
    logic [4:0]  offset  = 5'd0;
    logic [15:0] phase;
    logic        locked;
    logic        sync;

    int mcnt   = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          c;
        int          off;
        bit          clr;
        bit          win;
        logic [15:0] ph;
        bit          lk;
        int          np;
        int          pc;
    } vec_t;

    vec_t v[27];

    sysref_phase_tracker #(
        .PERIOD     (24),
        .LOCK_COUNT (4),
        .MISS_LIMIT (48)
    ) dut (
        .aclk_i        (aclk),
        .aresetn_i     (aresetn),
        .sysref_i      (sysref),
        .sync_offset_i (offset),
        .clear_i       (clear),
        .phase_o       (phase),
        .locked_o      (locked),
        .sync_o        (sync)
    );

    always #1.333 aclk = ~aclk;

    // Reference free-running counter (valid while no realign load occurs).
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) mcnt <= 0;
        else          mcnt <= (mcnt == P - 1) ? 0 : mcnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One-cycle SYSREF pulse; samples status right after the capturing edge.
    task automatic rise_now(input bit clr, output logic [15:0] ph, output logic lk);
        sysref = 1'b1;
        clear  = clr;
        @(negedge aclk);
        ph     = phase;
        lk     = locked;
        sysref = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic sysref_at(input int c, input bit clr, output logic [15:0] ph, output logic lk);
        int i;
        i = 0;
        while (mcnt != c && i < 4 * P) begin
            @(negedge aclk);
            i++;
        end
        chk("rise_wait", mcnt, c);
        rise_now(clr, ph, lk);
    endtask

    // Observes one full period; reports pulse count, counter value compared, and cycle index.
    task automatic sync_window(output int n, output int last_cnt, output int last_idx);
        n        = 0;
        last_cnt = -1;
        last_idx = -1;
        for (int i = 1; i <= P; i++) begin
            @(negedge aclk);
            if (sync) begin
                n++;
                last_cnt = (mcnt + P - 1) % P;
                last_idx = i;
            end
        end
    endtask

    task automatic clear_alone(input logic [15:0] exp);
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
        chk("clear_alone phase", phase, exp);
    endtask

    task automatic run_rows(input int lo, input int hi);
        logic [15:0] ph;
        logic        lk;
        int          n, lc, li;
        for (int k = lo; k <= hi; k++) begin
            offset = v[k].off[4:0];
            sysref_at(v[k].c, v[k].clr, ph, lk);
            chk($sformatf("row%0d phase", k), ph, v[k].ph);
            chk($sformatf("row%0d locked", k), lk, v[k].lk);
            if (v[k].win) begin
                sync_window(n, lc, li);
                chk($sformatf("row%0d sync_count", k), n, v[k].np);
                if (v[k].np > 0) chk($sformatf("row%0d sync_cnt", k), lc, v[k].pc);
            end
        end
    endtask

    initial begin
        logic [15:0] ph;
        logic        lk;
        int          n, lc, li;

        //        c   off clr win phase      lk  np pc
        v[0]  = '{5,  7,  0,  0,  16'h0105, 0,  0, 0};
        v[1]  = '{5,  7,  0,  0,  16'h1105, 0,  0, 0};
        v[2]  = '{5,  7,  0,  0,  16'h2105, 0,  0, 0};
        v[3]  = '{5,  7,  0,  0,  16'h3105, 0,  0, 0};
        v[4]  = '{5,  7,  0,  0,  16'h4305, 1,  0, 0};
        v[5]  = '{5,  7,  0,  1,  16'h4305, 1,  1, 12};
        v[6]  = '{5,  30, 0,  1,  16'h4305, 1,  1, 11};
        v[7]  = '{6,  7,  0,  1,  16'h0506, 0,  0, 0};
        v[8]  = '{6,  7,  0,  0,  16'h1506, 0,  0, 0};
        v[9]  = '{6,  7,  0,  0,  16'h2506, 0,  0, 0};
        v[10] = '{6,  7,  0,  0,  16'h3506, 0,  0, 0};
        v[11] = '{6,  7,  0,  0,  16'h4706, 1,  0, 0};
        v[12] = '{23, 7,  1,  0,  16'h0517, 0,  0, 0};
        v[13] = '{23, 31, 0,  0,  16'h1117, 0,  0, 0};
        v[14] = '{23, 31, 0,  0,  16'h2117, 0,  0, 0};
        v[15] = '{23, 31, 0,  0,  16'h3117, 0,  0, 0};
        v[16] = '{23, 31, 0,  1,  16'h4317, 1,  1, 6};
        v[17] = '{23, 31, 0,  0,  16'h4317, 1,  0, 0};
        v[18] = '{23, 7,  0,  0,  16'h1117, 0,  0, 0};
        v[19] = '{23, 7,  0,  0,  16'h2117, 0,  0, 0};
        v[20] = '{23, 7,  0,  0,  16'h3117, 0,  0, 0};
        v[21] = '{23, 7,  0,  0,  16'h4317, 1,  0, 0};
        v[22] = '{5,  7,  0,  0,  16'h0105, 0,  0, 0};
        v[23] = '{5,  7,  0,  0,  16'h1105, 0,  0, 0};
        v[24] = '{5,  7,  0,  0,  16'h2105, 0,  0, 0};
        v[25] = '{5,  7,  0,  0,  16'h3105, 0,  0, 0};
        v[26] = '{5,  7,  0,  1,  16'h4305, 1,  1, 12};

        #5;
        chk("reset phase", phase, 16'h0000);
        chk("reset locked", locked, 0);
        chk("reset sync", sync, 0);
        @(negedge aclk);
        aresetn = 1'b1;

`ifdef SYSREF_PHASE_REALIGN_EN
        offset = 5'd7;
        sysref_at(5, 0, ph, lk);
        chk("realign rise0 phase", ph, 16'h0100);
        for (int k = 1; k < 5; k++) begin
            repeat (P - 1) @(negedge aclk);
            rise_now(0, ph, lk);
            chk($sformatf("realign rise%0d phase", k), ph, (k == 4) ? 16'h4300 : 16'((k << 12) | 16'h0100));
        end
        chk("realign locked", lk, 1);
        sync_window(n, lc, li);
        chk("realign sync_count", n, 1);
        chk("realign sync_pos", li, 7);
`else
        // Lock at 5, sync timing for offsets 7 and 30, then a one-cycle slip and relock.
        run_rows(0, 11);
        clear_alone(16'h4306);
        // Slip and clear in the same cycle: the set must win.
        run_rows(12, 12);
        clear_alone(16'h0117);
        run_rows(13, 17);

        // Missing: 47 quiet edges after the last rise are fine, the 48th sets the flag.
        repeat (47) @(negedge aclk);
        chk("miss_47 phase", phase, 16'h4317);
        @(negedge aclk);
        chk("miss_48 phase", phase, 16'h0917);
        chk("miss_48 locked", locked, 0);
        clear_alone(16'h0117);
        run_rows(18, 21);

        // Asynchronous reset while locked, deliberately off the clock edge.
        @(posedge aclk);
        #0.4;
        aresetn = 1'b0;
        #0.1;
        chk("async_rst phase", phase, 16'h0000);
        chk("async_rst locked", locked, 0);
        chk("async_rst sync", sync, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        run_rows(22, 26);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
